// File: rtl/mem_copy_dma.sv
// mem_copy_dma: register-programmed word copy engine.
// Software loads SRC/DST/LEN through the config port and pulses CTRL.start.
// The engine then alternates one read and one write per word on the host bus,
// with at most one bus transaction outstanding.
module mem_copy_dma #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int MaxLenWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   device_req_i,
    input  logic [AddrWidth-1:0]   device_addr_i,
    input  logic                   device_we_i,
    input  logic [3:0]             device_be_i,
    input  logic [DataWidth-1:0]   device_wdata_i,
    output logic                   device_rvalid_o,
    output logic [DataWidth-1:0]   device_rdata_o,
    output logic                   host_req_o,
    input  logic                   host_gnt_i,
    output logic [AddrWidth-1:0]   host_addr_o,
    output logic                   host_we_o,
    output logic [3:0]             host_be_o,
    output logic [DataWidth-1:0]   host_wdata_o,
    input  logic                   host_rvalid_i,
    input  logic [DataWidth-1:0]   host_rdata_i,
    input  logic                   host_err_i,
    output logic                   irq_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;

    localparam logic [2:0] SEL_SRC    = 3'd0;
    localparam logic [2:0] SEL_DST    = 3'd1;
    localparam logic [2:0] SEL_LEN    = 3'd2;
    localparam logic [2:0] SEL_CTRL   = 3'd3;
    localparam logic [2:0] SEL_STATUS = 3'd4;

    logic [2:0]             state;
    logic [AddrWidth-1:0]   src_q, dst_q, cur_src, cur_dst;
    logic [MaxLenWidth-1:0] len_q, remaining;
    logic [DataWidth-1:0]   data_buf;
    logic                   ie_q, done_q, err_q;

    logic                   busy, cfg_wr, start_cmd, rsp_err, last_wr, done_set;
    logic [2:0]             reg_sel;
    logic [AddrWidth-1:0]   src_wr, dst_wr;
    logic [MaxLenWidth-1:0] len_wr;
    logic [DataWidth-1:0]   rd_mux;

    // Address bits outside [4:2] do not select a register.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{device_addr_i[AddrWidth-1:5], device_addr_i[1:0]};

    // Merge write data into an old value one byte lane at a time.
    function automatic logic [DataWidth-1:0] be_merge(input logic [DataWidth-1:0] old_val,
                                                      input logic [DataWidth-1:0] wr_val,
                                                      input logic [3:0]           be);
        logic [DataWidth-1:0] res;
        res = old_val;
        for (int i = 0; i < DataWidth / 8 && i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = wr_val[i*8 +: 8];
        end
        return res;
    endfunction

    assign reg_sel   = device_addr_i[4:2];
    assign busy      = (state != IDLE);
    assign cfg_wr    = device_req_i & device_we_i;
    assign start_cmd = cfg_wr && (reg_sel == SEL_CTRL) && device_be_i[0]
                       && device_wdata_i[0] && !busy;
    assign rsp_err   = host_rvalid_i && host_err_i && (state == RD_WAIT || state == WR_WAIT);
    assign last_wr   = (state == WR_WAIT) && host_rvalid_i && !host_err_i
                       && (remaining == MaxLenWidth'(1));
    assign done_set  = rsp_err | last_wr | (start_cmd && (len_q == '0));
    assign irq_o     = done_q & ie_q;

    // Byte-enable merged write values; word addresses keep the low two bits clear.
    always_comb begin
        src_wr      = AddrWidth'(be_merge(DataWidth'(src_q), device_wdata_i, device_be_i));
        src_wr[1:0] = 2'b00;
        dst_wr      = AddrWidth'(be_merge(DataWidth'(dst_q), device_wdata_i, device_be_i));
        dst_wr[1:0] = 2'b00;
        len_wr      = MaxLenWidth'(be_merge(DataWidth'(len_q), device_wdata_i, device_be_i));
    end

    // Register read multiplexer; undecoded offsets return zero.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            SEL_SRC:    rd_mux = DataWidth'(src_q);
            SEL_DST:    rd_mux = DataWidth'(dst_q);
            SEL_LEN:    rd_mux = DataWidth'(len_q);
            SEL_CTRL:   rd_mux[1] = ie_q;
            SEL_STATUS: rd_mux[2:0] = {err_q, done_q, busy};
            default:    rd_mux = '0;
        endcase
    end

    // Config response: one cycle after every request, read data registered with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= (device_req_i && !device_we_i) ? rd_mux : '0;
        end
    end

    // Software-visible configuration; SRC/DST/LEN are frozen while a copy runs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            ie_q  <= 1'b0;
        end else if (cfg_wr) begin
            if (!busy && reg_sel == SEL_SRC) src_q <= src_wr;
            if (!busy && reg_sel == SEL_DST) dst_q <= dst_wr;
            if (!busy && reg_sel == SEL_LEN) len_q <= len_wr;
            if (reg_sel == SEL_CTRL && device_be_i[0]) ie_q <= device_wdata_i[1];
        end
    end

    // Sticky done/err flags: start clears, software W1C clears, hardware set wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (start_cmd) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end else if (cfg_wr && reg_sel == SEL_STATUS && device_be_i[0]) begin
                if (device_wdata_i[1]) done_q <= 1'b0;
                if (device_wdata_i[2]) err_q  <= 1'b0;
            end
            if (done_set) done_q <= 1'b1;
            if (rsp_err)  err_q  <= 1'b1;
        end
    end

    // Copy sequencer: read a word, write it, advance pointers, repeat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            data_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        cur_src   <= src_q;
                        cur_dst   <= dst_q;
                        remaining <= len_q;
                        if (len_q != '0) state <= RD_REQ;
                    end
                end
                RD_REQ:  if (host_gnt_i) state <= RD_WAIT;
                RD_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            state <= IDLE;
                        end else begin
                            data_buf <= host_rdata_i;
                            state    <= WR_REQ;
                        end
                    end
                end
                WR_REQ:  if (host_gnt_i) state <= WR_WAIT;
                WR_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            state <= IDLE;
                        end else begin
                            remaining <= remaining - MaxLenWidth'(1);
                            cur_src   <= cur_src + AddrWidth'(4);
                            cur_dst   <= cur_dst + AddrWidth'(4);
                            state     <= last_wr ? IDLE : RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host bus drive: outputs are a pure function of state, so they hold while waiting for grant.
    always_comb begin
        host_req_o   = (state == RD_REQ) || (state == WR_REQ);
        host_we_o    = (state == WR_REQ);
        host_be_o    = 4'hF;
        host_addr_o  = '0;
        host_wdata_o = '0;
        if (state == RD_REQ) host_addr_o = cur_src;
        if (state == WR_REQ) begin
            host_addr_o  = cur_dst;
            host_wdata_o = data_buf;
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Testbench for mem_copy_dma: directed register programming, a bus responder
// that returns a fixed data pattern, and scoreboard queues checked by monitors.
module tb_mem_copy_dma;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          device_req_i;
    logic [AW-1:0] device_addr_i;
    logic          device_we_i;
    logic [3:0]    device_be_i;
    logic [DW-1:0] device_wdata_i;
    logic          device_rvalid_o;
    logic [DW-1:0] device_rdata_o;
    logic          host_req_o;
    logic          host_gnt_i;
    logic [AW-1:0] host_addr_o;
    logic          host_we_o;
    logic [3:0]    host_be_o;
    logic [DW-1:0] host_wdata_o;
    logic          host_rvalid_i;
    logic [DW-1:0] host_rdata_i;
    logic          host_err_i;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    mem_copy_dma #(.AddrWidth(AW), .DataWidth(DW), .MaxLenWidth(LW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .device_req_i(device_req_i), .device_addr_i(device_addr_i),
        .device_we_i(device_we_i), .device_be_i(device_be_i),
        .device_wdata_i(device_wdata_i), .device_rvalid_o(device_rvalid_o),
        .device_rdata_o(device_rdata_o),
        .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
        .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
        .host_err_i(host_err_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- config-port scoreboard ----------------
    bit          cfg_isrd_q[$];
    logic [31:0] cfg_exp_q[$];
    string       cfg_name_q[$];
    bit          pop_isrd;
    logic [31:0] pop_exp;
    string       pop_name;

    always @(negedge clk) begin
        if (!rst_i && device_rvalid_o) begin
            if (cfg_isrd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cfg_unexpected: rvalid with no pending request");
            end else begin
                pop_isrd = cfg_isrd_q.pop_front();
                pop_exp  = cfg_exp_q.pop_front();
                pop_name = cfg_name_q.pop_front();
                if (pop_isrd) check(pop_name, device_rdata_o, pop_exp);
            end
        end
    end

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cfg_isrd_q.push_back(1'b0);
        cfg_exp_q.push_back(32'h0);
        cfg_name_q.push_back("wr");
        device_req_i = 1'b1; device_we_i = 1'b1; device_addr_i = a;
        device_wdata_i = d; device_be_i = be;
        @(posedge clk); #1;
        device_req_i = 1'b0; device_we_i = 1'b0;
    endtask

    task automatic cfg_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        cfg_isrd_q.push_back(1'b1);
        cfg_exp_q.push_back(exp);
        cfg_name_q.push_back(name);
        device_req_i = 1'b1; device_we_i = 1'b0; device_addr_i = a; device_be_i = 4'hF;
        @(posedge clk); #1;
        device_req_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- host-bus scoreboard and responder ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;
    bus_t bus_q[$];
    bus_t bexp;

    int          stall_cycles = 0;
    int          rd_count = 0;
    int          err_read_num = -1;
    bit          pend = 0;
    bit          pend_err = 0;
    logic [31:0] pend_data;
    bit          stalling = 0;
    logic [31:0] stall_addr;
    logic        stall_we;

    task automatic push_rd(input logic [31:0] a);
        bus_q.push_back({1'b0, a, 32'h0});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        bus_q.push_back({1'b1, a, d});
    endtask

    initial begin
        host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = '0;
        forever begin
            @(negedge clk);
            host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0;
            if (rst_i) begin
                pend = 0; pend_err = 0; stalling = 0;
            end else if (pend) begin
                host_rvalid_i = 1'b1; host_rdata_i = pend_data; host_err_i = pend_err;
                pend = 0; pend_err = 0;
            end else if (host_req_o) begin
                if (stalling) begin
                    check("stall_addr", host_addr_o, stall_addr);
                    check("stall_we", host_we_o, stall_we);
                end else begin
                    stall_addr = host_addr_o; stall_we = host_we_o;
                end
                if (stall_cycles > 0) begin
                    stalling = 1;
                    stall_cycles--;
                end else begin
                    stalling = 0;
                    host_gnt_i = 1'b1;
                    pend = 1;
                    check("bus_be", host_be_o, 4'hF);
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL bus_unexpected: got we=%0b addr=%0h expected no request",
                                 host_we_o, host_addr_o);
                    end else begin
                        bexp = bus_q.pop_front();
                        check("bus_we", host_we_o, bexp.we);
                        check("bus_addr", host_addr_o, bexp.addr);
                        if (bexp.we) check("bus_wdata", host_wdata_o, bexp.wdata);
                    end
                    if (!host_we_o) begin
                        rd_count++;
                        pend_data = 32'hDA7A0000 | {16'h0, host_addr_o[15:0]};
                        pend_err  = (rd_count == err_read_num);
                    end else begin
                        pend_data = 32'h0;
                        pend_err  = 1'b0;
                    end
                end
            end else begin
                stalling = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, host_req_o, 1'b0);
        check({tag, "_we"}, host_we_o, 1'b0);
        check({tag, "_addr"}, host_addr_o, 32'h0);
        check({tag, "_wdata"}, host_wdata_o, 32'h0);
        check({tag, "_rvalid"}, device_rvalid_o, 1'b0);
        check({tag, "_rdata"}, device_rdata_o, 32'h0);
        check({tag, "_irq"}, irq_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_i = 1'b1; device_req_i = 1'b0; device_addr_i = '0; device_we_i = 1'b0;
        device_be_i = 4'h0; device_wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_i = 1'b0;

        cfg_read("rst_src", 32'h00, 32'h0);
        cfg_read("rst_status", 32'h10, 32'h0);

        // Byte enables, low-bit forcing, undecoded offset
        cfg_write(32'h00, 32'h12345677, 4'b0101);
        cfg_read("be_src", 32'h00, 32'h00340074);
        cfg_write(32'h08, 32'h0000AB00, 4'b0010);
        cfg_read("be_len", 32'h08, 32'h0000AB00);
        cfg_write(32'h14, 32'hFFFFFFFF, 4'hF);
        cfg_read("undecoded", 32'h14, 32'h0);

        // Basic three-word copy
        push_rd(32'h100); push_wr(32'h200, 32'hDA7A0100);
        push_rd(32'h104); push_wr(32'h204, 32'hDA7A0104);
        push_rd(32'h108); push_wr(32'h208, 32'hDA7A0108);
        cfg_write(32'h00, 32'h100, 4'hF);
        cfg_write(32'h04, 32'h200, 4'hF);
        cfg_write(32'h08, 32'h3, 4'hF);
        cfg_write(32'h0C, 32'h1, 4'hF);
        wait_cycles(20);
        cfg_read("copy3_status", 32'h10, 32'h2);
        cfg_read("copy3_ctrl", 32'h0C, 32'h0);
        cfg_read("copy3_src", 32'h00, 32'h100);
        check("copy3_irq", irq_o, 1'b0);

        // Zero-length start and done W1C
        cfg_write(32'h10, 32'h2, 4'hF);
        cfg_read("clr_status", 32'h10, 32'h0);
        cfg_write(32'h0C, 32'h2, 4'hF);
        cfg_read("ie_ctrl", 32'h0C, 32'h2);
        cfg_write(32'h08, 32'h0, 4'hF);
        cfg_write(32'h0C, 32'h3, 4'hF);
        check("len0_irq", irq_o, 1'b1);
        check("len0_req", host_req_o, 1'b0);
        cfg_read("len0_status", 32'h10, 32'h2);
        cfg_write(32'h10, 32'h2, 4'hF);
        check("len0_irq_clr", irq_o, 1'b0);
        cfg_read("len0_status_clr", 32'h10, 32'h0);

        // Grant held off five cycles
        push_rd(32'h300); push_wr(32'h400, 32'hDA7A0300);
        cfg_write(32'h00, 32'h300, 4'hF);
        cfg_write(32'h04, 32'h400, 4'hF);
        cfg_write(32'h08, 32'h1, 4'hF);
        stall_cycles = 5;
        cfg_write(32'h0C, 32'h3, 4'hF);
        wait_cycles(20);
        cfg_read("stall_status", 32'h10, 32'h2);
        check("stall_irq", irq_o, 1'b1);
        cfg_write(32'h10, 32'h2, 4'hF);

        // Bus error on the second read
        push_rd(32'h500); push_wr(32'h600, 32'hDA7A0500); push_rd(32'h504);
        cfg_write(32'h00, 32'h500, 4'hF);
        cfg_write(32'h04, 32'h600, 4'hF);
        cfg_write(32'h08, 32'h4, 4'hF);
        err_read_num = rd_count + 2;
        cfg_write(32'h0C, 32'h3, 4'hF);
        wait_cycles(20);
        cfg_read("err_status", 32'h10, 32'h6);
        check("err_irq", irq_o, 1'b1);
        err_read_num = -1;
        cfg_write(32'h10, 32'h6, 4'hF);
        cfg_read("err_status_clr", 32'h10, 32'h0);

        // Source address wraps past the top of the address space
        push_rd(32'hFFFFFFFC); push_wr(32'h700, 32'hDA7AFFFC);
        push_rd(32'h00000000); push_wr(32'h704, 32'hDA7A0000);
        cfg_write(32'h00, 32'hFFFFFFFC, 4'hF);
        cfg_write(32'h04, 32'h700, 4'hF);
        cfg_write(32'h08, 32'h2, 4'hF);
        cfg_write(32'h0C, 32'h3, 4'hF);
        wait_cycles(20);
        cfg_read("wrap_status", 32'h10, 32'h2);
        cfg_write(32'h10, 32'h2, 4'hF);

        // Writes while busy, then reset in the middle of a transfer
        cfg_write(32'h00, 32'h800, 4'hF);
        cfg_write(32'h04, 32'h900, 4'hF);
        cfg_write(32'h08, 32'h3, 4'hF);
        stall_cycles = 30;
        cfg_write(32'h0C, 32'h3, 4'hF);
        cfg_write(32'h00, 32'hABC, 4'hF);
        cfg_read("busy_src", 32'h00, 32'h800);
        cfg_read("busy_status", 32'h10, 32'h1);
        wait_cycles(2);
        check("busy_req", host_req_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_i = 1'b0;
        stall_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            check("postrst_req", host_req_o, 1'b0);
            wait_cycles(1);
        end
        cfg_read("postrst_status", 32'h10, 32'h0);
        cfg_read("postrst_src", 32'h00, 32'h0);
        wait_cycles(3);

        check("bus_q_drained", bus_q.size(), 0);
        check("cfg_q_drained", cfg_isrd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
